ps2_host_tx: RTL and testbench

//  PS/2 host-to-device transmitter; counterpart of the keyboard/mouse receive path on PS2CLKA/PS2DATA and PS2CLKB/PS2DATB.

---
 rtl/ps2_pkg.sv | 29 ++
 rtl/ps2_line_filter.sv | 58 +++++
 rtl/ps2_host_tx.sv | 210 +++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM states, frame geometry and default timing.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    ACK,
    WAITIDLE,
    FAIL
  } ps2_state_e;

  // Start + 8 data + parity + stop; the host shifts out everything after the start bit.
  localparam int PS2_FRAME_BITS = 11;
  localparam int PS2_SHIFT_BITS = PS2_FRAME_BITS - 1;

  // Default timing at a 25 MHz system clock.
  localparam int PS2_INHIBIT_CYCLES = 2500;    // 100 us
  localparam int PS2_START_TIMEOUT  = 375000;  // 15 ms
  localparam int PS2_FRAME_TIMEOUT  = 50000;   // 2 ms
  localparam int PS2_FILTER_LEN     = 8;

  // Host frame as shifted out LSB first: data, odd parity, stop.
  function automatic logic [PS2_SHIFT_BITS-1:0] ps2_build_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus a run-length deglitch filter for one PS/2 line.
// A level change is accepted only after FILTER_LEN consecutive differing samples.
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = PS2_FILTER_LEN
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic fall_o
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          fall_q, fall_d;

  // Synchroniser, run counter and filtered level; idle lines are high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      cnt_q   <= '0;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      fall_q  <= fall_d;
    end
  end

  // Count differing samples; any agreeing sample restarts the run.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    fall_d  = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        fall_d  = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign level_o = level_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send,
// clock out data/parity/stop on device falling edges, then sample the ACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
  parameter int START_TIMEOUT  = PS2_START_TIMEOUT,
  parameter int FRAME_TIMEOUT  = PS2_FRAME_TIMEOUT,
  parameter int FILTER_LEN     = PS2_FILTER_LEN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       err,
  input  logic       ps2clk_i,
  input  logic       ps2dat_i,
  output logic       ps2clk_oe,
  output logic       ps2dat_oe
);

  // One shared timer serves inhibit, start wait and frame wait; it must hold the largest.
  localparam int MAX_A = (START_TIMEOUT > FRAME_TIMEOUT) ? START_TIMEOUT : FRAME_TIMEOUT;
  localparam int MAX_T = (MAX_A > INHIBIT_CYCLES) ? MAX_A : INHIBIT_CYCLES;
  localparam int CW    = $clog2(MAX_T + 1);

  localparam logic [CW-1:0] INH_LAST   = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] START_LAST = CW'(START_TIMEOUT - 1);
  localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_TIMEOUT - 1);
  localparam logic [CW-1:0] TMR_MAX    = '1;

  // Index 0 = clock line, index 1 = data line.
  logic [1:0] raw_line;
  logic [1:0] lvl;
  logic [1:0] fall;
  logic       clk_fall;
  logic       unused_dat_fall;

  assign raw_line = {ps2dat_i, ps2clk_i};

  for (genvar gi = 0; gi < 2; gi++) begin : g_filt
    ps2_line_filter #(
      .FILTER_LEN(FILTER_LEN)
    ) u_filt (
      .clk    (clk),
      .rst    (rst),
      .raw_i  (raw_line[gi]),
      .level_o(lvl[gi]),
      .fall_o (fall[gi])
    );
  end

  assign clk_fall = fall[0];
  // The data-line fall strobe is only needed by the receiver.
  assign unused_dat_fall = fall[1];

  ps2_state_e                 state_q, state_d;
  logic [CW-1:0]              tmr_q, tmr_d;
  logic [PS2_SHIFT_BITS-1:0]  shift_q, shift_d;
  logic [3:0]                 bitcnt_q, bitcnt_d;
  logic                       clk_oe_q, clk_oe_d;
  logic                       dat_oe_q, dat_oe_d;
  logic                       done_q, done_d;
  logic                       ack_q, ack_d;
  logic                       err_q, err_d;
  logic                       timeout;

  // State, timer, shift register and registered pad enables.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      tmr_q    <= '0;
      shift_q  <= '0;
      bitcnt_q <= '0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
      done_q   <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      clk_oe_q <= clk_oe_d;
      dat_oe_q <= dat_oe_d;
      done_q   <= done_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
    end
  end

  // Timeouts are checked before any fall so that a coincident edge loses.
  always_comb begin
    timeout = 1'b0;
    if (state_q == REQ) begin
      timeout = (tmr_q >= START_LAST);
    end else if (state_q == SEND || state_q == ACK || state_q == WAITIDLE) begin
      timeout = (tmr_q >= FRAME_LAST);
    end
  end

  // Next-state logic; the *_oe_d values are the pad enables for the next cycle.
  always_comb begin
    state_d  = state_q;
    tmr_d    = (tmr_q == TMR_MAX) ? tmr_q : tmr_q + CW'(1);
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    clk_oe_d = 1'b0;
    dat_oe_d = 1'b0;
    done_d   = 1'b0;
    ack_d    = ack_q;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        tmr_d = '0;
        if (tx_valid) begin
          shift_d  = ps2_build_frame(tx_data);
          bitcnt_d = '0;
          ack_d    = 1'b0;
          err_d    = 1'b0;
          state_d  = INHIBIT;
          clk_oe_d = 1'b1;
          dat_oe_d = (INH_LAST == '0);
        end
      end
      INHIBIT: begin
        if (tmr_q >= INH_LAST) begin
          // Release the clock with data held low: request-to-send.
          state_d  = REQ;
          tmr_d    = '0;
          dat_oe_d = 1'b1;
        end else begin
          clk_oe_d = 1'b1;
          dat_oe_d = ((tmr_q + CW'(1)) == INH_LAST);
        end
      end
      REQ: begin
        dat_oe_d = 1'b1;
        if (clk_fall) begin
          // Fall 1 starts the frame timer, counted as its first cycle.
          state_d  = SEND;
          tmr_d    = CW'(1);
          dat_oe_d = ~shift_q[0];
          shift_d  = {1'b1, shift_q[PS2_SHIFT_BITS-1:1]};
          bitcnt_d = bitcnt_q + 4'd1;
        end
      end
      SEND: begin
        dat_oe_d = dat_oe_q;
        if (clk_fall) begin
          dat_oe_d = ~shift_q[0];
          shift_d  = {1'b1, shift_q[PS2_SHIFT_BITS-1:1]};
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_q == 4'd9) begin
            state_d = ACK;
          end
        end
      end
      ACK: begin
        if (clk_fall) begin
          bitcnt_d = bitcnt_q + 4'd1;
          if (lvl[1]) begin
            err_d = 1'b1;
          end else begin
            ack_d = 1'b1;
          end
          state_d = WAITIDLE;
        end
      end
      WAITIDLE: begin
        if (lvl[0] && lvl[1]) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      FAIL: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (timeout) begin
      state_d  = FAIL;
      shift_d  = shift_q;
      bitcnt_d = bitcnt_q;
      clk_oe_d = 1'b0;
      dat_oe_d = 1'b0;
      done_d   = 1'b1;
      ack_d    = 1'b0;
      err_d    = 1'b1;
    end
  end

  assign tx_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign ack_ok    = ack_q;
  assign err       = err_q;
  assign ps2clk_oe = clk_oe_q;
  assign ps2dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a device model clocks the frame, a bit queue holds the
// bits the device must see, a result queue holds the expected ack/err per done.
module tb_ps2_host_tx;

  localparam int INH      = 2500;
  localparam int START_TO = 3000;
  localparam int FRAME_TO = 2000;
  localparam int FLEN     = 8;
  localparam int HALF     = 40;   // device clock half period in system cycles

  localparam int M_ACK    = 0;
  localparam int M_NACK   = 1;
  localparam int M_NOCLK  = 2;
  localparam int M_STOP5  = 3;
  localparam int M_RST    = 4;
  localparam int M_GLITCH = 5;
  localparam int M_BUSY   = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, done, ack_ok, err;
  logic       ps2clk_i, ps2dat_i, ps2clk_oe, ps2dat_oe;
  logic       bfm_clk = 1'b1;
  logic       bfm_dat = 1'b1;

  // Open-drain lines with pull-ups: either side can pull low.
  assign ps2clk_i = bfm_clk & ~ps2clk_oe;
  assign ps2dat_i = bfm_dat & ~ps2dat_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .START_TIMEOUT (START_TO),
    .FRAME_TIMEOUT (FRAME_TO),
    .FILTER_LEN    (FLEN)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .done     (done),
    .ack_ok   (ack_ok),
    .err      (err),
    .ps2clk_i (ps2clk_i),
    .ps2dat_i (ps2dat_i),
    .ps2clk_oe(ps2clk_oe),
    .ps2dat_oe(ps2dat_oe)
  );

  always #20 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input int got, input int want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0d want=%0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  logic       bit_q[$];
  logic [1:0] res_q[$];   // {ack_ok, err}
  logic [1:0] res_exp;
  int         done_cnt = 0;
  int         done_cyc = 0;

  // Every done pulse is matched against the oldest expected result.
  always @(negedge clk) begin
    if (!rst && done) begin
      done_cnt++;
      done_cyc = cyc;
      if (res_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        res_exp = res_q.pop_front();
        chk("ack_ok", int'(ack_ok), int'(res_exp[1]));
        chk("err", int'(err), int'(res_exp[0]));
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Device-side sample of the data line, compared with the next expected bit.
  task automatic bfm_sample(input string tag);
    logic e;
    if (bit_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 0, 1);
    end else begin
      e = bit_q.pop_front();
      chk(tag, int'(ps2dat_i), int'(e));
    end
  endtask

  task automatic wait_done(input int start_cnt, input int budget);
    int n;
    n = 0;
    while (done_cnt == start_cnt && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (done_cnt == start_cnt) chk("done_timeout", 0, 1);
  endtask

  task automatic do_xfer(input logic [7:0] d, input int mode);
    logic [9:0] fr;
    int ones, nsamp, nclk, dc0, inh_len, dat_cnt, n, rel_cyc, f1_cyc;
    logic [1:0] want;

    ones = 0;
    for (int b = 0; b < 8; b++) if (d[b]) ones++;
    // Stop, odd parity (set when the data has an even number of ones), data.
    fr = {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, d};

    case (mode)
      M_NOCLK: nsamp = 0;
      M_STOP5: nsamp = 5;
      M_RST:   nsamp = 4;
      default: nsamp = 10;
    endcase
    bit_q.push_back(1'b0);  // start bit seen at request-to-send
    for (int b = 0; b < nsamp; b++) bit_q.push_back(fr[b]);

    want = (mode == M_ACK || mode == M_GLITCH || mode == M_BUSY) ? 2'b10 : 2'b01;
    if (mode != M_RST) res_q.push_back(want);
    dc0 = done_cnt;
    f1_cyc = 0;

    tx_data  = d;
    tx_valid = 1'b1;
    wait_cyc(1);
    tx_valid = 1'b0;

    // Inhibit: clock held low; data must join only in the last cycle.
    inh_len = 0;
    dat_cnt = 0;
    n = 0;
    @(negedge clk);
    while (ps2clk_oe && n < 10000) begin
      inh_len++;
      if (ps2dat_oe) dat_cnt++;
      @(negedge clk);
      n++;
    end
    rel_cyc = cyc;
    chk("inhibit_len", inh_len, INH);
    chk("inhibit_dat_cycles", dat_cnt, 1);
    bfm_sample("start_bit");

    if (mode == M_NOCLK) begin
      wait_done(dc0, START_TO + 100);
      chk("start_to_cycles", done_cyc - rel_cyc, START_TO);
      chk("to_oe", int'({ps2clk_oe, ps2dat_oe}), 0);
    end else begin
      nclk = (mode == M_STOP5 || mode == M_RST) ? 5 : 11;
      for (int i = 1; i <= nclk; i++) begin
        wait_cyc(HALF);
        if (i == 11 && mode != M_NACK) begin
          bfm_dat = 1'b0;
          wait_cyc(4);
        end
        bfm_clk = 1'b0;
        if (i == 1) f1_cyc = cyc;
        if (mode == M_RST && i == 5) begin
          wait_cyc(HALF / 2);
          rst = 1'b1;
          wait_cyc(1);
          chk("rst_clk_oe", int'(ps2clk_oe), 0);
          chk("rst_dat_oe", int'(ps2dat_oe), 0);
          rst = 1'b0;
          break;
        end
        if (mode == M_BUSY && i == 3) begin
          tx_data  = 8'h3C;
          tx_valid = 1'b1;
          wait_cyc(1);
          tx_valid = 1'b0;
          tx_data  = d;
        end
        wait_cyc(HALF);
        bfm_clk = 1'b1;
        if (i <= 10) bfm_sample($sformatf("bit%0d", i));
        if (i == 11) bfm_dat = 1'b1;
        if (mode == M_GLITCH && i >= 2 && i <= 4) begin
          wait_cyc(5);
          bfm_clk = 1'b0;
          wait_cyc(3);
          bfm_clk = 1'b1;
          wait_cyc(FLEN + 6);
          chk("glitch_bitcnt", int'(u_dut.bitcnt_q), i);
        end
      end

      if (mode == M_RST) begin
        bfm_clk = 1'b1;
        bfm_dat = 1'b1;
        wait_cyc(200);
        chk("rst_no_done", done_cnt, dc0);
        chk("rst_tx_ready", int'(tx_ready), 1);
      end else if (mode == M_STOP5) begin
        wait_done(dc0, FRAME_TO + 500);
        // The filtered fall strobe lags the pad edge by 2 sync + FLEN filter cycles.
        chk("frame_to_cycles", done_cyc - f1_cyc, FLEN + 2 + FRAME_TO);
        chk("frame_to_oe", int'({ps2clk_oe, ps2dat_oe}), 0);
      end else begin
        wait_done(dc0, 1000);
      end
    end

    if (mode != M_RST) begin
      wait_cyc(10);
      chk("done_single", int'(done), 0);
      chk("ack_hold", int'(ack_ok), int'(want[1]));
      chk("err_hold", int'(err), int'(want[0]));
    end
    if (mode == M_BUSY) begin
      wait_cyc(50);
      chk("busy_pulse_dropped", int'(busy), 0);
    end
    chk("bits_left", bit_q.size(), 0);
    $display("xfer data=%02h mode=%0d ack_ok=%0d err=%0d done_count=%0d",
             d, mode, ack_ok, err, done_cnt);
    wait_cyc(20);
  endtask

  initial begin
    rst = 1'b1;
    wait_cyc(5);
    chk("reset_tx_ready", int'(tx_ready), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_ack_err", int'({ack_ok, err}), 0);
    chk("reset_oe", int'({ps2clk_oe, ps2dat_oe}), 0);
    rst = 1'b0;
    wait_cyc(20);

    do_xfer(8'hED, M_ACK);
    do_xfer(8'h00, M_BUSY);
    do_xfer(8'hFF, M_ACK);
    do_xfer(8'h5A, M_NOCLK);
    do_xfer(8'hF4, M_STOP5);
    do_xfer(8'hF4, M_NACK);
    do_xfer(8'hA5, M_RST);
    do_xfer(8'hED, M_GLITCH);

    chk("results_left", res_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
